// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer for an output-stationary systolic array: splits an m x k by k x n GEMM
// into ARRAY x ARRAY output tiles, streams operands, drains the array and stores result rows.
module tpu_tile_scheduler #(
  parameter int ARRAY     = 5,
  parameter int ADDR_W    = 8,
  parameter int DIM_W     = 4,
  parameter int DRAIN_CYC = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     m,
  input  logic [DIM_W-1:0]     k,
  input  logic [DIM_W-1:0]     n,
  output logic [ADDR_W-1:0]    a_addr,
  output logic                 a_ren,
  output logic [ADDR_W-1:0]    b_addr,
  output logic                 b_ren,
  output logic                 sa_clear,
  output logic                 sa_valid,
  output logic [2:0]           sa_row_sel,
  input  logic [ARRAY*8-1:0]   sa_row_data,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_wen,
  output logic [ARRAY*8-1:0]   out_wdata,
  output logic                 busy,
  output logic                 done
);

  localparam int DCW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t           r_state;
  logic [DIM_W-1:0] r_m, r_k, r_n;
  logic [DIM_W-1:0] r_tr, r_tc;
  logic [DIM_W-1:0] r_trow, r_tcol;
  logic [DIM_W-1:0] r_kk;
  logic [DCW-1:0]   r_dcnt;
  logic [2:0]       r_row;

  logic [DIM_W-1:0]  w_tr_in, w_tc_in, w_rem, w_rows;
  logic              w_zero, w_last_col, w_last_row, w_last_k, w_last_r;
  logic [ADDR_W-1:0] w_a_base, w_b_base, w_out_base;

  function automatic logic [DIM_W-1:0] ceil_div(input logic [DIM_W-1:0] x);
    logic [DIM_W:0] t;
    t = {1'b0, x} + (DIM_W+1)'(ARRAY - 1);
    return DIM_W'(t / (DIM_W+1)'(ARRAY));
  endfunction

  always_comb begin
    w_tr_in    = ceil_div(m);
    w_tc_in    = ceil_div(n);
    w_zero     = (m == '0) || (k == '0) || (n == '0);
    w_a_base   = ADDR_W'(r_trow) * ADDR_W'(r_k);
    w_b_base   = ADDR_W'(r_tcol) * ADDR_W'(r_k);
    w_out_base = ADDR_W'(r_trow) * ADDR_W'(ARRAY) * ADDR_W'(r_tc) + ADDR_W'(r_tcol);
    w_rem      = r_m - r_trow * DIM_W'(ARRAY);
    w_rows     = (w_rem > DIM_W'(ARRAY)) ? DIM_W'(ARRAY) : w_rem;
    w_last_col = (r_tcol == r_tc - DIM_W'(1));
    w_last_row = (r_trow == r_tr - DIM_W'(1));
    w_last_k   = (r_kk == r_k - DIM_W'(1));
    w_last_r   = (DIM_W'(r_row) == w_rows - DIM_W'(1));
  end

  assign out_wdata = sa_row_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_m        <= '0;
      r_k        <= '0;
      r_n        <= '0;
      r_tr       <= '0;
      r_tc       <= '0;
      r_trow     <= '0;
      r_tcol     <= '0;
      r_kk       <= '0;
      r_dcnt     <= '0;
      r_row      <= '0;
      a_addr     <= '0;
      a_ren      <= 1'b0;
      b_addr     <= '0;
      b_ren      <= 1'b0;
      sa_clear   <= 1'b0;
      sa_valid   <= 1'b0;
      sa_row_sel <= '0;
      out_addr   <= '0;
      out_wen    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_m    <= m;
            r_k    <= k;
            r_n    <= n;
            r_tr   <= w_tr_in;
            r_tc   <= w_tc_in;
            r_trow <= '0;
            r_tcol <= '0;
            if (w_zero) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state  <= S_CLEAR;
              done     <= 1'b0;
              busy     <= 1'b1;
              sa_clear <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state  <= S_FEED;
          sa_clear <= 1'b0;
          r_kk     <= '0;
          a_ren    <= 1'b1;
          b_ren    <= 1'b1;
          sa_valid <= 1'b1;
          a_addr   <= w_a_base;
          b_addr   <= w_b_base;
        end
        S_FEED: begin
          if (w_last_k) begin
            r_state  <= S_DRAIN;
            r_dcnt   <= '0;
            a_ren    <= 1'b0;
            b_ren    <= 1'b0;
            sa_valid <= 1'b0;
          end else begin
            r_kk   <= r_kk + DIM_W'(1);
            a_addr <= a_addr + ADDR_W'(1);
            b_addr <= b_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DCW'(DRAIN_CYC - 1)) begin
            r_state    <= S_WRITE;
            r_row      <= '0;
            sa_row_sel <= '0;
            out_wen    <= 1'b1;
            out_addr   <= w_out_base;
          end else begin
            r_dcnt <= r_dcnt + DCW'(1);
          end
        end
        S_WRITE: begin
          if (w_last_r) begin
            out_wen    <= 1'b0;
            sa_row_sel <= '0;
            // tile_col is the inner loop; wrapping it advances tile_row
            if (w_last_col) begin
              r_tcol <= '0;
              if (w_last_row) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_trow   <= r_trow + DIM_W'(1);
                r_state  <= S_CLEAR;
                sa_clear <= 1'b1;
              end
            end else begin
              r_tcol   <= r_tcol + DIM_W'(1);
              r_state  <= S_CLEAR;
              sa_clear <= 1'b1;
            end
          end else begin
            r_row      <= r_row + 3'd1;
            sa_row_sel <= r_row + 3'd1;
            out_addr   <= out_addr + ADDR_W'(r_tc);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler: per-job read/write streams and done latency
// are checked against a loop model of the tiling order.
module tb_tpu_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  m = '0, k = '0, n = '0;
  logic [7:0]  a_addr, b_addr, out_addr;
  logic        a_ren, b_ren, sa_clear, sa_valid, out_wen, busy, done;
  logic [2:0]  sa_row_sel;
  logic [39:0] sa_row_data, out_wdata;

  int          n_chk = 0;
  int          n_pass = 0;
  int          tile_cnt = 0;
  int          valid_cnt = 0;
  int          a_q[$];
  int          b_q[$];
  int          wa_q[$];
  logic [39:0] wd_q[$];

  always #5 clk = ~clk;

  tpu_tile_scheduler #(.ARRAY(5), .ADDR_W(8), .DIM_W(4), .DRAIN_CYC(9)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n),
    .a_addr(a_addr), .a_ren(a_ren), .b_addr(b_addr), .b_ren(b_ren),
    .sa_clear(sa_clear), .sa_valid(sa_valid), .sa_row_sel(sa_row_sel),
    .sa_row_data(sa_row_data), .out_addr(out_addr), .out_wen(out_wen),
    .out_wdata(out_wdata), .busy(busy), .done(done)
  );

  // Array stand-in: each lane carries the tile ordinal and the selected row.
  assign sa_row_data = {5{8'(tile_cnt * 16 + int'(sa_row_sel))}};

  always @(negedge clk) begin
    if (sa_clear) tile_cnt++;
    if (sa_valid) valid_cnt++;
    if (a_ren) a_q.push_back(int'(a_addr));
    if (b_ren) b_q.push_back(int'(b_addr));
    if (out_wen) begin
      wa_q.push_back(int'(out_addr));
      wd_q.push_back(out_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [33:0] outs();
    return {a_addr, a_ren, b_addr, b_ren, sa_clear, sa_valid, sa_row_sel,
            out_addr, out_wen, busy, done};
  endfunction

  task automatic run_job(input int mm, input int kk, input int nn, input bit glitch,
                         input string tag);
    int ea[$];
    int eb[$];
    int ewa[$];
    logic [39:0] ewd[$];
    logic [39:0] d;
    int a0, b0, w0, base, v0, c0, tr_n, tc_n, t, rows, exp_cyc, cyc;
    a0 = a_q.size(); b0 = b_q.size(); w0 = wa_q.size();
    base = tile_cnt; v0 = valid_cnt;
    tr_n = (mm + 4) / 5; tc_n = (nn + 4) / 5;
    if (mm == 0 || kk == 0 || nn == 0) begin tr_n = 0; tc_n = 0; end
    t = 0; exp_cyc = 0;
    for (int tr = 0; tr < tr_n; tr++) begin
      for (int tc = 0; tc < tc_n; tc++) begin
        for (int j = 0; j < kk; j++) begin
          ea.push_back((tr * kk + j) % 256);
          eb.push_back((tc * kk + j) % 256);
        end
        rows = (mm - 5 * tr > 5) ? 5 : mm - 5 * tr;
        for (int r = 0; r < rows; r++) begin
          ewa.push_back(((tr * 5 + r) * tc_n + tc) % 256);
          d = {5{8'((base + t + 1) * 16 + r)}};
          ewd.push_back(d);
        end
        exp_cyc += 1 + kk + 9 + rows;
        t++;
      end
    end

    @(negedge clk);
    m = 4'(mm); k = 4'(kk); n = 4'(nn); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".accept_done"}, 64'(done), 64'(t == 0));
    chk({tag, ".accept_busy"}, 64'(busy), 64'(t != 0));
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (glitch && cyc == 3) begin start = 1'b1; m = 4'd2; end
      else if (glitch && cyc == 4) begin start = 1'b0; m = 4'(mm); end
    end
    chk({tag, ".done_edges"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".tiles"}, 64'(tile_cnt - base), 64'(t));
    chk({tag, ".valid_cycles"}, 64'(valid_cnt - v0), 64'(t * kk));
    chk({tag, ".n_reads"}, 64'(a_q.size() - a0), 64'(ea.size()));
    chk({tag, ".n_writes"}, 64'(wa_q.size() - w0), 64'(ewa.size()));
    for (int i = 0; i < ea.size() && a0 + i < a_q.size() && b0 + i < b_q.size(); i++) begin
      chk($sformatf("%s.a_addr[%0d]", tag, i), 64'(a_q[a0 + i]), 64'(ea[i]));
      chk($sformatf("%s.b_addr[%0d]", tag, i), 64'(b_q[b0 + i]), 64'(eb[i]));
    end
    for (int i = 0; i < ewa.size() && w0 + i < wa_q.size(); i++) begin
      chk($sformatf("%s.out_addr[%0d]", tag, i), 64'(wa_q[w0 + i]), 64'(ewa[i]));
      chk($sformatf("%s.out_data[%0d]", tag, i), 64'(wd_q[w0 + i]), 64'(ewd[i]));
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".done_hold"}, 64'({done, busy, out_wen, a_ren}), 64'(4'b1000));
  endtask

  initial begin
    int w0, a0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outs", 64'(outs()), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle.outs", 64'(outs()), 64'(0));

    run_job(5, 5, 5, 1'b0, "j555");
    run_job(7, 3, 8, 1'b0, "j738");
    run_job(5, 0, 5, 1'b0, "jk0");
    run_job(7, 5, 5, 1'b1, "jglitch");

    // Abort a job mid-DRAIN with a one-cycle reset.
    @(negedge clk);
    m = 4'd5; k = 4'd5; n = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort.in_drain", 64'({busy, a_ren, out_wen}), 64'(3'b100));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.outs", 64'(outs()), 64'(0));
    w0 = wa_q.size(); a0 = a_q.size();
    repeat (25) @(posedge clk);
    #1;
    chk("abort.no_writes", 64'(wa_q.size() - w0), 64'(0));
    chk("abort.no_reads", 64'(a_q.size() - a0), 64'(0));
    chk("abort.idle", 64'(outs()), 64'(0));

    run_job(5, 5, 5, 1'b0, "jclean");
    run_job(10, 4, 5, 1'b0, "jredo");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
